trb_mem_ctrl: RTL



---
 rtl/trb_mem_ctrl_pkg.sv | 25 ++
 rtl/trb_mem_ctrl_if.sv | 41 ++++
 rtl/trb_mem_ctrl_ram.sv | 29 ++
 rtl/trb_mem_ctrl.sv | 156 +++++++++++++++
 4 files changed

// File: rtl/trb_mem_ctrl_pkg.sv
// Shared types and sizing for the trace buffer memory controller.
package trb_mem_ctrl_pkg;

  localparam int TRB_WIDTH     = 32;
  localparam int TRB_DEPTH     = 16;
  localparam int TRB_ADDR_BITS = $clog2(TRB_DEPTH);

  typedef logic [TRB_WIDTH-1:0]     trb_word_t;
  typedef logic [TRB_ADDR_BITS-1:0] trb_addr_t;
  typedef logic [TRB_ADDR_BITS:0]   trb_count_t;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_TRACE  = 3'd1,
    ST_POST   = 3'd2,
    ST_DONE   = 3'd3,
    ST_STREAM = 3'd4
  } trb_state_e;

  // Pointer increment that wraps naturally at TRB_DEPTH (power of two).
  function automatic trb_addr_t next_addr(input trb_addr_t a);
    return trb_addr_t'(a + trb_addr_t'(1));
  endfunction

endpackage

// File: rtl/trb_mem_ctrl_if.sv
// Tracer/system bus of the trace buffer controller.
// Handshake: load is a one-cycle request with no backpressure; the controller
// answers with load_valid high for exactly one cycle, with rd_data valid in
// that same cycle. rd_data holds its value until the next answered read.
// store and sys_we are fire-and-forget write strobes sampled every cycle.
interface trb_mem_ctrl_if;
  import trb_mem_ctrl_pkg::*;

  logic       en;
  logic       mode;
  logic       trg_event;
  trb_addr_t  post_trg;
  logic       store;
  trb_word_t  wr_data;
  logic       load;
  trb_word_t  rd_data;
  logic       load_valid;
  logic       sys_we;
  trb_word_t  sys_data;
  trb_addr_t  event_addr;
  trb_addr_t  wr_ptr;
  logic       wrapped;
  logic       done;
  logic       full;
  logic       empty;
  logic       ovf;
  trb_state_e state;

  modport master (
    output en, mode, trg_event, post_trg, store, wr_data, load, sys_we, sys_data,
    input  rd_data, load_valid, event_addr, wr_ptr, wrapped, done, full, empty,
           ovf, state
  );

  modport slave (
    input  en, mode, trg_event, post_trg, store, wr_data, load, sys_we, sys_data,
    output rd_data, load_valid, event_addr, wr_ptr, wrapped, done, full, empty,
           ovf, state
  );

endinterface

// File: rtl/trb_mem_ctrl_ram.sv
// Simple dual-port synchronous RAM, one write and one read port.
// A read and a write to the same address in one cycle return the old word.
module trb_ram
  import trb_mem_ctrl_pkg::*;
(
  input  logic      clk,
  input  logic      rst_n,
  input  logic      we,
  input  trb_addr_t waddr,
  input  trb_word_t wdata,
  input  logic      re,
  input  trb_addr_t raddr,
  output trb_word_t q
);

  trb_word_t mem [TRB_DEPTH];

  // Storage array, deliberately not reset.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  // Registered read port; holds the last word read until the next read.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)  q <= '0;
    else if (re) q <= mem[raddr];
  end

endmodule

// File: rtl/trb_mem_ctrl.sv
// Trace buffer memory controller: circular trace capture with trigger and
// post-trigger window, or a FIFO stream from the system side to the tracer.
module trb_mem_ctrl
  import trb_mem_ctrl_pkg::*;
(
  input logic           clk,
  input logic           rst_n,
  trb_mem_ctrl_if.slave bus
);

  trb_state_e state, state_nxt;

  trb_addr_t  wr_ptr, rd_ptr, event_addr;
  trb_addr_t  post_cnt;
  trb_count_t count;
  logic       wrapped, done, ovf, pending;
  logic       load_valid;
  logic       use_byp;
  trb_word_t  byp_data;
  trb_word_t  ram_q;

  logic       full_c, empty_c;
  logic       start_c, trace_mode_c, trace_wr_c, trace_rd_c, trig_c, post_last_c;
  logic       stream_c, st_wr_c, st_rd_c, st_drop_c, service_c, pend_set_c;
  logic       ram_we_c, ram_re_c;
  trb_addr_t  ram_raddr_c;
  trb_word_t  ram_wdata_c;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic; mode is only looked at when leaving IDLE.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:   if (bus.en) state_nxt = bus.mode ? ST_STREAM : ST_TRACE;
      ST_TRACE:  if (!bus.en) state_nxt = ST_IDLE;
                 else if (bus.trg_event) state_nxt = ST_POST;
      ST_POST:   if (!bus.en) state_nxt = ST_IDLE;
                 else if (bus.store && post_cnt == '0) state_nxt = ST_DONE;
      ST_DONE:   if (!bus.en) state_nxt = ST_IDLE;
      ST_STREAM: if (!bus.en) state_nxt = ST_IDLE;
      default:   state_nxt = ST_IDLE;
    endcase
  end

  // Per-cycle actions decoded from state and requests.
  always_comb begin
    full_c       = (count == trb_count_t'(TRB_DEPTH));
    empty_c      = (count == '0);
    start_c      = (state == ST_IDLE) && bus.en;
    trace_mode_c = bus.en && (state == ST_TRACE || state == ST_POST || state == ST_DONE);
    trace_wr_c   = bus.en && bus.store && (state == ST_TRACE || state == ST_POST);
    trace_rd_c   = trace_mode_c && bus.load;
    trig_c       = bus.en && (state == ST_TRACE) && bus.trg_event;
    post_last_c  = bus.en && (state == ST_POST) && bus.store && (post_cnt == '0);
    stream_c     = bus.en && (state == ST_STREAM);
    st_wr_c      = stream_c && bus.sys_we && !full_c;
    st_drop_c    = stream_c && bus.sys_we && full_c;
    st_rd_c      = stream_c && bus.load && !empty_c;
    // A waiting (or same-cycle) read on an empty FIFO takes the written word directly.
    service_c    = st_wr_c && (pending || (bus.load && empty_c));
    pend_set_c   = stream_c && bus.load && empty_c && !st_wr_c;
    ram_we_c     = trace_wr_c || st_wr_c;
    ram_wdata_c  = stream_c ? bus.sys_data : bus.wr_data;
    ram_re_c     = trace_rd_c || st_rd_c;
    ram_raddr_c  = stream_c ? rd_ptr : wr_ptr;
  end

  // Pointers, counters and sticky status flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      post_cnt   <= '0;
      event_addr <= '0;
      wrapped    <= 1'b0;
      done       <= 1'b0;
      ovf        <= 1'b0;
      pending    <= 1'b0;
    end else if (start_c) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      post_cnt   <= '0;
      event_addr <= '0;
      wrapped    <= 1'b0;
      done       <= 1'b0;
      ovf        <= 1'b0;
      pending    <= 1'b0;
    end else begin
      if (ram_we_c) wr_ptr <= next_addr(wr_ptr);
      if (trace_wr_c && wr_ptr == trb_addr_t'(TRB_DEPTH - 1)) wrapped <= 1'b1;
      if (trig_c) begin
        event_addr <= trace_wr_c ? next_addr(wr_ptr) : wr_ptr;
        post_cnt   <= bus.post_trg;
      end else if (trace_wr_c && state == ST_POST && post_cnt != '0) begin
        post_cnt <= post_cnt - trb_addr_t'(1);
      end
      if (post_last_c) done <= 1'b1;
      if (st_drop_c) ovf <= 1'b1;
      if (st_rd_c || service_c) rd_ptr <= next_addr(rd_ptr);
      case ({st_wr_c, st_rd_c || service_c})
        2'b10:   count <= count + trb_count_t'(1);
        2'b01:   count <= count - trb_count_t'(1);
        default: count <= count;
      endcase
      if (service_c)       pending <= 1'b0;
      else if (pend_set_c) pending <= 1'b1;
    end
  end

  // Read-return path: one-cycle valid pulse and bypass for serviced pending reads.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      load_valid <= 1'b0;
      use_byp    <= 1'b0;
      byp_data   <= '0;
    end else begin
      load_valid <= ram_re_c || service_c;
      if (service_c) begin
        use_byp  <= 1'b1;
        byp_data <= bus.sys_data;
      end else if (ram_re_c) begin
        use_byp  <= 1'b0;
      end
    end
  end

  trb_ram u_ram (
    .clk   (clk),
    .rst_n (rst_n),
    .we    (ram_we_c),
    .waddr (wr_ptr),
    .wdata (ram_wdata_c),
    .re    (ram_re_c),
    .raddr (ram_raddr_c),
    .q     (ram_q)
  );

  assign bus.rd_data    = use_byp ? byp_data : ram_q;
  assign bus.load_valid = load_valid;
  assign bus.event_addr = event_addr;
  assign bus.wr_ptr     = wr_ptr;
  assign bus.wrapped    = wrapped;
  assign bus.done       = done;
  assign bus.full       = full_c;
  assign bus.empty      = empty_c;
  assign bus.ovf        = ovf;
  assign bus.state      = state;

endmodule
